// File: rtl/masked_relu_seq.sv
// Masked ReLU over a vector job: a two-stage pipeline computes the remasked result
// per element, with a small FSM that sequences a job of len elements.
module masked_relu_seq #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] e_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    // vld_q[0] is stage 1 (u, g, last), vld_q[1] is stage 2 (o_out, out_last)
    logic [1:0]       vld_q, vld_d;
    logic [WIDTH-1:0] u1_q, u1_d;
    logic [WIDTH-1:0] g1_q, g1_d;
    logic             last1_q, last1_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             last2_q, last2_d;
    logic             done_q, done_d;

    logic             advance;
    logic             in_fire;
    logic             out_fire;
    logic             is_last;
    logic [WIDTH-1:0] u_in;

    assign advance  = !vld_q[1] | out_ready;
    assign in_ready = (state_q == RUN) & advance;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = vld_q[1] & out_ready;
    assign is_last  = (cnt_q == (len_q - LEN_W'(1)));
    assign u_in     = g_in + e_in;

    assign out_valid = vld_q[1];
    assign o_out     = o_q;
    assign out_last  = last2_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = RUN;
                        len_d   = len;
                        cnt_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (is_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && last2_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Both stages move together only when stage 2 can drain; otherwise everything holds.
    always_comb begin
        vld_d   = vld_q;
        u1_d    = u1_q;
        g1_d    = g1_q;
        last1_d = last1_q;
        o_d     = o_q;
        last2_d = last2_q;
        if (advance) begin
            vld_d = {vld_q[0], in_fire};
            if (in_fire) begin
                u1_d    = u_in;
                g1_d    = g_in;
                last1_d = is_last;
            end
            if (vld_q[0]) begin
                // Negative u collapses to the bare mask share, i.e. a masked zero.
                o_d = u1_q[WIDTH-1] ? g1_q : (u1_q + g1_q);
            end
            last2_d = vld_q[0] & last1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            u1_q    <= '0;
            g1_q    <= '0;
            last1_q <= 1'b0;
            o_q     <= '0;
            last2_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            u1_q    <= u1_d;
            g1_q    <= g1_d;
            last1_q <= last1_d;
            o_q     <= o_d;
            last2_q <= last2_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_masked_relu_seq.sv
// Randomized bench for masked_relu_seq against a signed-arithmetic reference model.
module tb_masked_relu_seq;
    localparam int W = 64;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  g_in, e_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  o_out;
    logic          out_last;
    logic          busy;
    logic          done;

    masked_relu_seq #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .g_in(g_in), .e_in(e_in),
        .out_valid(out_valid), .out_ready(out_ready), .o_out(o_out),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] gv[$], ev[$], got[$];
    logic         gotl[$];
    int           acc_cyc[$], out_cyc[$];
    int           extra_in, ov_cnt, stall_bad, done_cnt, done_cyc, timeout;
    logic         busy_at_done, busy_first;

    // Treat the masked value as a signed number: non-negative passes through remasked.
    function automatic logic [W-1:0] ref_o(input logic [W-1:0] g, input logic [W-1:0] e);
        logic [W-1:0] u;
        u = g + e;
        if ($signed(u) >= 0) return u + g;
        return g;
    endfunction

    // Runs one job from gv/ev and records what came out; the tests judge the record.
    task automatic run_job(input int n, input int in_pct, input int rdy_pct, input bit chained);
        int           sent;
        int           cyc;
        logic         stalled;
        logic [W-1:0] hold_o;
        logic         hold_l;
        sent = 0; stalled = 1'b0; hold_o = '0; hold_l = 1'b0;
        got.delete(); gotl.delete(); acc_cyc.delete(); out_cyc.delete();
        extra_in = 0; ov_cnt = 0; stall_bad = 0; done_cnt = 0; done_cyc = -1; timeout = 0;
        busy_at_done = 1'b1; busy_first = 1'b0;
        if (!chained) @(negedge clk);
        start = 1'b1; len = LW'(n); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            len = LW'($urandom_range(0, 20));
            in_valid = (sent < n) ? ($urandom_range(0, 99) < in_pct) : 1'b1;
            g_in = (sent < n) ? gv[sent] : {$urandom, $urandom};
            e_in = (sent < n) ? ev[sent] : {$urandom, $urandom};
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (cyc == 0) busy_first = busy;
            if (stalled && (!out_valid || o_out !== hold_o || out_last !== hold_l))
                stall_bad++;
            if (in_valid && in_ready) begin
                if (sent < n) begin
                    acc_cyc.push_back(cyc);
                    sent++;
                end else extra_in++;
            end
            if (out_valid) ov_cnt++;
            if (out_valid && out_ready) begin
                got.push_back(o_out); gotl.push_back(out_last); out_cyc.push_back(cyc);
            end
            stalled = out_valid && !out_ready;
            hold_o = o_out; hold_l = out_last;
            if (done) begin
                done_cnt++; done_cyc = cyc; busy_at_done = busy;
                break;
            end
            @(posedge clk);
        end
        if (done_cyc < 0) timeout = 1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1;
        g_in = '0; e_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || o_out !== '0)
            $display("FAIL reset_outputs: got rdy=%b ov=%b last=%b busy=%b done=%b o=%h, want all 0",
                     in_ready, out_valid, out_last, busy, done, o_out);
        else passes++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        gv = '{64'd5}; ev = '{-64'd2};
        run_job(1, 100, 100, 1'b0);
        checks++;
        if (timeout != 0 || got.size() != 1)
            $display("FAIL single_count: got %0d results timeout=%0d, want 1", got.size(), timeout);
        else begin
            passes++;
            checks++;
            if (got[0] !== 64'd8 || gotl[0] !== 1'b1)
                $display("FAIL single_value: got %h last=%b, want 8 last=1", got[0], gotl[0]);
            else passes++;
            checks++;
            if (out_cyc[0] - acc_cyc[0] != 2)
                $display("FAIL single_latency: got %0d, want 2", out_cyc[0] - acc_cyc[0]);
            else passes++;
            checks++;
            if (done_cyc != out_cyc[0] + 1 || busy_at_done !== 1'b0)
                $display("FAIL single_done: done at %0d busy=%b, want %0d busy=0",
                         done_cyc, busy_at_done, out_cyc[0] + 1);
            else passes++;
        end
    endtask

    task automatic test_negative;
        gv = '{64'd7, 64'h8000_0000_0000_0000}; ev = '{-64'd10, 64'd0};
        run_job(2, 100, 100, 1'b0);
        checks++;
        if (got.size() != 2 || got[0] !== 64'd7 || got[1] !== 64'h8000_0000_0000_0000)
            $display("FAIL negative_wrap: got n=%0d %h %h, want 7 8000000000000000",
                     got.size(), (got.size() > 0) ? got[0] : '0, (got.size() > 1) ? got[1] : '0);
        else passes++;
    endtask

    task automatic test_stream;
        logic [W-1:0] exp;
        int           bad;
        gv.delete(); ev.delete();
        for (int i = 0; i < 8; i++) begin
            gv.push_back({$urandom, $urandom}); ev.push_back({$urandom, $urandom});
        end
        run_job(8, 100, 100, 1'b0);
        checks++;
        if (timeout != 0 || got.size() != 8)
            $display("FAIL stream_count: got %0d timeout=%0d, want 8", got.size(), timeout);
        else begin
            passes++;
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                exp = ref_o(gv[i], ev[i]);
                checks++;
                if (got[i] !== exp || gotl[i] !== (i == 7) || out_cyc[i] != out_cyc[0] + i)
                    $display("FAIL stream_elem%0d: got %h last=%b cyc=%0d, want %h last=%b cyc=%0d",
                             i, got[i], gotl[i], out_cyc[i], exp, (i == 7), out_cyc[0] + i);
                else passes++;
            end
            checks++;
            if (extra_in != 0 || acc_cyc[7] != acc_cyc[0] + 7)
                $display("FAIL stream_input: extra=%0d last_acc=%0d, want 0 and %0d",
                         extra_in, acc_cyc[7], acc_cyc[0] + 7);
            else passes++;
        end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL stream_done_pulse: got done=%b busy=%b, want 0 0", done, busy);
        else passes++;
    endtask

    task automatic test_backpressure;
        int bad;
        gv.delete(); ev.delete();
        for (int i = 0; i < 16; i++) begin
            gv.push_back({$urandom, $urandom}); ev.push_back({$urandom, $urandom});
        end
        run_job(16, 70, 45, 1'b0);
        bad = 0;
        for (int i = 0; i < 16 && i < got.size(); i++)
            if (got[i] !== ref_o(gv[i], ev[i]) || gotl[i] !== (i == 15)) bad++;
        checks++;
        if (timeout != 0 || got.size() != 16 || bad != 0)
            $display("FAIL bp_results: got n=%0d bad=%0d timeout=%0d, want n=16 bad=0",
                     got.size(), bad, timeout);
        else passes++;
        checks++;
        if (stall_bad != 0 || extra_in != 0 || done_cnt != 1)
            $display("FAIL bp_stall: got unstable=%0d extra=%0d done=%0d, want 0 0 1",
                     stall_bad, extra_in, done_cnt);
        else passes++;
    endtask

    task automatic test_len_zero;
        gv.delete(); ev.delete();
        run_job(0, 100, 100, 1'b0);
        checks++;
        if (timeout != 0 || done_cyc != 0 || extra_in != 0 || ov_cnt != 0 || busy_at_done !== 1'b0)
            $display("FAIL len0: got done_cyc=%0d in=%0d ov=%0d busy=%b, want 0 0 0 0",
                     done_cyc, extra_in, ov_cnt, busy_at_done);
        else passes++;
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL len0_pulse: got done=%b busy=%b, want 0 0", done, busy);
        else passes++;
    endtask

    task automatic test_back_to_back;
        gv = '{64'd1, 64'd2}; ev = '{64'd3, -64'd9};
        run_job(2, 100, 100, 1'b0);
        gv = '{64'd100, 64'd4, 64'd6}; ev = '{64'd20, -64'd1, -64'd7};
        run_job(3, 100, 100, 1'b1);
        checks++;
        if (busy_first !== 1'b1 || got.size() != 3 || got[0] !== 64'd220 ||
            got[1] !== 64'd7 || got[2] !== 64'd6)
            $display("FAIL back_to_back: got busy=%b n=%0d, want busy=1 n=3 220 7 6",
                     busy_first, got.size());
        else passes++;
    endtask

    task automatic test_rst_mid;
        int acc;
        int ov_after;
        acc = 0;
        @(negedge clk);
        start = 1'b1; len = LW'(8); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 50 && acc < 3; c++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1;
            g_in = {$urandom, $urandom}; e_in = {$urandom, $urandom};
            #1;
            if (in_ready) acc++;
            @(posedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || o_out !== '0)
            $display("FAIL rst_mid_clear: got rdy=%b ov=%b last=%b busy=%b o=%h, want all 0",
                     in_ready, out_valid, out_last, busy, o_out);
        else passes++;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        ov_after = 0;
        repeat (5) begin
            @(negedge clk); #1;
            if (out_valid || busy) ov_after++;
        end
        checks++;
        if (ov_after != 0 || acc != 3)
            $display("FAIL rst_mid_stale: got stale=%0d accepted=%0d, want 0 3", ov_after, acc);
        else passes++;
        gv = '{64'd11, 64'd5}; ev = '{64'd1, -64'd6};
        run_job(2, 100, 100, 1'b0);
        checks++;
        if (got.size() != 2 || got[0] !== 64'd23 || got[1] !== 64'd5 || gotl[1] !== 1'b1)
            $display("FAIL rst_mid_rejob: got n=%0d, want 2 results 23 5", got.size());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_negative();
        test_stream();
        test_backpressure();
        test_len_zero();
        test_back_to_back();
        test_rst_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/masked_relu_seq.md
MASKED_RELU_SEQ -- requirements
Module: masked_relu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning datapath word width.
REQ-002 SHALL have parameter LEN_W, default 16, meaning vector-length counter width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning begin a vector job, sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  meaning element count of the job, captured with start.
REQ-007 SHALL have port in_valid  input  1  meaning g_in/e_in carry a valid element.
REQ-008 SHALL have port in_ready  output  1  meaning the block accepts an element this cycle.
REQ-009 SHALL have port g_in  input  WIDTH  meaning mask share of the element.
REQ-010 SHALL have port e_in  input  WIDTH  meaning masked ReLU input of the element.
REQ-011 SHALL have port out_valid  output  1  meaning o_out holds a valid result.
REQ-012 SHALL have port out_ready  input  1  meaning the consumer accepts o_out this cycle.
REQ-013 SHALL have port o_out  output  WIDTH  meaning remasked ReLU result.
REQ-014 SHALL have port out_last  output  1  meaning o_out is the final element of the job.
REQ-015 SHALL have port busy  output  1  meaning state is not IDLE.
REQ-016 SHALL have port done  output  1  meaning one-cycle pulse at job completion.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN; IDLE->RUN on start with len>0; RUN->DRAIN when element len-1 is accepted at input; DRAIN->IDLE when the last result is accepted at output (out_valid & out_ready & out_last).
REQ-018 SHALL, on start with len==0 in IDLE, remain in IDLE, perform no transfers, and pulse done on the following cycle.
REQ-019 SHALL ignore start while busy; len SHALL NOT be re-captured mid-job.
REQ-020 SHALL compute per element u = (g_in + e_in) mod 2^WIDTH, and o_out = (u[WIDTH-1]==0) ? (u + g_in) mod 2^WIDTH : g_in.
REQ-021 SHALL use a two-stage pipeline: stage 1 registers u, g_in and a last flag; stage 2 registers o_out and out_last; latency from input handshake to out_valid SHALL be exactly 2 cycles when unstalled.
REQ-022 SHALL define advance = !out_valid | out_ready; both stages SHALL hold all contents when advance is 0, with no element lost or duplicated.
REQ-023 SHALL drive in_ready = (state==RUN) & advance; an input transfer occurs on in_valid & in_ready.
REQ-024 SHALL count accepted elements from 0; the element accepted at count len-1 SHALL carry the last flag, and no further input SHALL be accepted in the job.
REQ-025 SHALL sustain one element per cycle throughput when out_ready is held high.
REQ-026 SHALL keep o_out and out_last stable while out_valid & !out_ready.
REQ-027 SHALL pulse done for exactly one cycle, the cycle after the last output handshake, concurrent with busy returning low.
REQ-028 SHALL accept a new start in the cycle done is high (state already IDLE).

Reset
REQ-029 SHALL, while rst is high, asynchronously force state IDLE, counter 0, both pipeline valid bits 0, in_ready 0, out_valid 0, out_last 0, busy 0, done 0, o_out 0.
REQ-030 SHALL, on rst asserted mid-job, discard all in-flight elements and resume in IDLE with no output after release.

Verification
REQ-031 SHALL verify single element: start, len=1; g=5, e=-2 (u=3) -> o_out=8, out_last=1, out_valid 2 cycles after accept, done next cycle after output handshake.
REQ-032 SHALL verify negative case: g=7, e=-10 (u=-3) -> o_out=7; and wrap: g=2^63, e=0, WIDTH=64 -> u sign=1 -> o_out=2^63.
REQ-033 SHALL verify streaming len=8 with out_ready=1 -> 8 results on consecutive cycles, out_last only on the 8th, in_ready low after 8th accept.
REQ-034 SHALL verify backpressure: random out_ready toggling over len=16 -> all 16 results in order, o_out stable during stalls, none dropped or duplicated.
REQ-035 SHALL verify len=0 start -> no in_ready, no out_valid, done pulses once the next cycle.
REQ-036 SHALL verify rst asserted after 3 of 8 elements accepted -> outputs cleared immediately, no stale out_valid after release; a new len=2 job completes correctly.
